// File: rtl/cv32e40x_div_iter.sv
// Iterative radix-2 divider/remainder unit (DIV, DIVU, REM, REMU), one quotient bit per cycle.
// Shares the multiplier's valid/ready handshake; dropping valid_i kills the operation.
module cv32e40x_div_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [1:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        valid_o,
  input  logic        ready_i
);

  typedef enum logic [1:0] {IDLE, DIVIDE, FINISH} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic [1:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] result_q, result_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, overflow;
  logic [32:0] rem_shift, diff;
  logic        q_bit;
  logic [31:0] rem_step, dvd_step;
  logic [31:0] raw_res, final_res;
  logic        neg_res;

  // operator_i[0]=1 selects unsigned, operator_i[1]=1 selects remainder
  assign signed_op   = ~operator_i[0];
  assign a_mag       = (signed_op && op_a_i[31]) ? (~op_a_i + 32'd1) : op_a_i;
  assign b_mag       = (signed_op && op_b_i[31]) ? (~op_b_i + 32'd1) : op_b_i;
  assign div_by_zero = (op_b_i == 32'd0);
  assign overflow    = signed_op && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);

  // Restoring step: the 33-bit difference's MSB is the borrow
  assign rem_shift = {rem_q, dvd_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};
  assign q_bit     = ~diff[32];
  assign rem_step  = q_bit ? diff[31:0] : rem_shift[31:0];
  assign dvd_step  = {dvd_q[30:0], q_bit};

  assign raw_res   = op_q[1] ? rem_step : dvd_step;
  assign neg_res   = op_q[1] ? rneg_q : qneg_q;
  assign final_res = neg_res ? (~raw_res + 32'd1) : raw_res;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    if (!valid_i) begin
      state_d  = IDLE;
      cnt_d    = 6'd0;
      rem_d    = 32'd0;
      dvd_d    = 32'd0;
      dvs_d    = 32'd0;
      result_d = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          op_d   = operator_i;
          qneg_d = signed_op && (op_a_i[31] ^ op_b_i[31]);
          rneg_d = signed_op && op_a_i[31];
          dvs_d  = b_mag;
          if (div_by_zero) begin
            result_d = operator_i[1] ? op_a_i : 32'hFFFF_FFFF;
            state_d  = FINISH;
          end else if (overflow) begin
            result_d = operator_i[1] ? 32'd0 : 32'h8000_0000;
            state_d  = FINISH;
          end else begin
            rem_d   = 32'd0;
            dvd_d   = a_mag;
            cnt_d   = 6'd31;
            state_d = DIVIDE;
          end
        end
        DIVIDE: begin
          rem_d = rem_step;
          dvd_d = dvd_step;
          if (cnt_q == 6'd0) begin
            result_d = final_res;
            state_d  = FINISH;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        FINISH: begin
          if (ready_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      rem_q    <= 32'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      op_q     <= 2'b00;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Gated by valid_i so a kill takes effect in the same cycle
  assign valid_o  = valid_i && (state_q == FINISH);
  assign ready_o  = !valid_i || (valid_o && ready_i);
  assign result_o = result_q;

`ifndef SYNTHESIS
  a_valid_in_finish: assert property (@(posedge clk) disable iff (!rst_n)
    valid_o |-> (state_q == FINISH));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= 6'd31);
  a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !ready_i) |=> $stable(result_o));
`endif

endmodule
